syncfifo_reader: RTL

Read-side drain controller for the team's synchronous FIFO (registered read data, valid one cycle after a qualified read). It watches the FIFO's empty flag and issues read enables. It absorbs the one-cycle read latency in a 3-entry prefetch buffer and presents words downstream on a valid/ready stream. It sustains one word per clock with no combinational path from m_ready to fifo_rd_en.

---
 rtl/syncfifo_reader_if.sv | 23 ++
 rtl/syncfifo_reader.sv | 100 ++++++++++
 2 files changed

// File: rtl/syncfifo_reader_if.sv
// FIFO-side and downstream-stream signal bundle for syncfifo_reader.
// The master modport is the reader's view; slave is the FIFO/sink side.
interface syncfifo_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       occupancy;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, occupancy
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, occupancy
  );
endinterface

// File: rtl/syncfifo_reader.sv
// Read-side drain controller: issues FIFO reads and absorbs the one-cycle read latency in a 3-entry prefetch buffer.
// Optional word counter (word_count/cnt_clr) is enabled by defining SYNCFIFO_READER_CNT_EN.
module syncfifo_reader #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  syncfifo_reader_if.master  bus
`ifdef SYNCFIFO_READER_CNT_EN
  ,
  output logic [15:0]        word_count,
  input  logic               cnt_clr
`endif
);

  logic [WIDTH-1:0] buf_q [3];
  logic [WIDTH-1:0] buf_d [3];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             capture;
  logic             pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue only when the slot for the returning word is already reserved,
  // so the decision never looks at the downstream handshake.
  assign bus.fifo_rd_en = ~reset & ~bus.fifo_empty &
                          (({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd3);
  assign capture        = inflight_q;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign pop            = bus.m_valid & bus.m_ready;
  assign bus.occupancy  = occ_q;

  always_comb begin
    case (rd_ptr_q)
      2'd1:    bus.m_data = buf_q[1];
      2'd2:    bus.m_data = buf_q[2];
      default: bus.m_data = buf_q[0];
    endcase
  end

  always_comb begin
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = bus.fifo_rd_en & ~bus.fifo_empty;
    if (capture) begin
      for (int i = 0; i < 3; i++) begin
        if (wr_ptr_q == i[1:0]) buf_d[i] = bus.fifo_dout;
      end
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef SYNCFIFO_READER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Clear wins over a coincident pop.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)  cnt_d = 16'd0;
    else if (pop) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign word_count = cnt_q;
`endif

endmodule
